// File: rtl/iot_pkg.sv
// Shared constants for the IoT frame scheduler: data width, function codes, FSM states.
package iot_pkg;

    localparam int DATA_W = 128;
    localparam int SUM_W  = DATA_W + 4;

    localparam logic [2:0] FN_RSVD = 3'b000;
    localparam logic [2:0] FN_MAX  = 3'b001;
    localparam logic [2:0] FN_MIN  = 3'b010;
    localparam logic [2:0] FN_AVG  = 3'b011;
    localparam logic [2:0] FN_EXT  = 3'b100;
    localparam logic [2:0] FN_EXC  = 3'b101;
    localparam logic [2:0] FN_PMAX = 3'b110;
    localparam logic [2:0] FN_PMIN = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_e;

    function automatic logic is_peak(input logic [2:0] fn);
        return (fn == FN_PMAX) || (fn == FN_PMIN);
    endfunction

endpackage

// File: rtl/iot_fn_sched_if.sv
// Frame-in / result-out bundle between a frame source and iot_fn_sched.
interface iot_fn_sched_if;
    import iot_pkg::*;

    logic [2:0]        fn_sel;
    logic              frm_vld;
    logic [DATA_W-1:0] frm_data;
    logic              frm_rdy;
    logic [DATA_W-1:0] iot_out;
    logic              valid;

    modport master (
        output fn_sel, frm_vld, frm_data,
        input  frm_rdy, iot_out, valid
    );

    modport slave (
        input  fn_sel, frm_vld, frm_data,
        output frm_rdy, iot_out, valid
    );
endinterface

// File: rtl/iot_acc_unit.sv
// Compare/accumulate datapath: running extreme, 132-bit round sum and range checks.
// Outputs are the post-update values so the scheduler can emit on the last accept.
module iot_acc_unit
    import iot_pkg::*;
#(
    parameter int                FRAMES_PER_ROUND = 8,
    parameter logic [DATA_W-1:0] EXT_LO = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
    parameter logic [DATA_W-1:0] EXT_HI = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_en_i,
    input  logic              first_i,
    input  logic              is_min_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] ext_nxt_o,
    output logic [DATA_W-1:0] avg_nxt_o,
    output logic              in_rng_o,
    output logic              out_rng_o
);
    localparam int SHIFT = $clog2(FRAMES_PER_ROUND);

    logic [DATA_W-1:0] ext_q, ext_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              take;

    always_comb begin
        // Strict compare: a tie keeps the stored extreme.
        take  = is_min_i ? (data_i < ext_q) : (data_i > ext_q);
        ext_d = (first_i || take) ? data_i : ext_q;
        sum_d = first_i ? {4'b0, data_i} : (sum_q + {4'b0, data_i});
    end

    assign ext_nxt_o = ext_d;
    assign avg_nxt_o = sum_d[SHIFT +: DATA_W];
    assign in_rng_o  = (data_i > EXT_LO) && (data_i < EXT_HI);
    assign out_rng_o = (data_i < EXT_LO) || (data_i > EXT_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q <= '0;
            sum_q <= '0;
        end else if (acc_en_i) begin
            ext_q <= ext_d;
            sum_q <= sum_d;
        end
    end

endmodule

// File: rtl/iot_fn_sched.sv
// IoT frame scheduler: FSM, frame index, latched function code and peak tracking.
// Define IOT_SCHED_PEAK_EN to build peak-max/peak-min; otherwise 110/111 act as max/min.
module iot_fn_sched
    import iot_pkg::*;
#(
    parameter int                FRAMES_PER_ROUND = 8,
    parameter logic [DATA_W-1:0] EXT_LO = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
    parameter logic [DATA_W-1:0] EXT_HI = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF
) (
    input  logic          clk,
    input  logic          rst,
    iot_fn_sched_if.slave bus
);
    localparam int         IDX_W     = $clog2(FRAMES_PER_ROUND);
    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_COLLECT = ST_COLLECT;
    localparam logic [1:0] S_EMIT    = ST_EMIT;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [2:0]        fn_q, fn_d, fn_eff;
    logic [DATA_W-1:0] out_q, out_d;
    logic              vld_q, vld_d;

    logic              accept, first, last, is_min;
    logic              sel_emit, emit, peak_ok;
    logic [DATA_W-1:0] sel_data, ext_nxt, avg_nxt;
    logic              in_rng, out_rng;

    assign bus.frm_rdy = (state_q == S_COLLECT);
    assign bus.iot_out = out_q;
    assign bus.valid   = vld_q;

    assign accept = bus.frm_vld && (state_q == S_COLLECT);
    assign first  = (idx_q == '0);
    assign last   = (idx_q == IDX_W'(FRAMES_PER_ROUND - 1));
    // The code presented with frame 0 governs that frame and the rest of its round.
    assign fn_eff = first ? bus.fn_sel : fn_q;
    assign is_min = (fn_eff == FN_MIN) || (fn_eff == FN_PMIN);

    iot_acc_unit #(
        .FRAMES_PER_ROUND (FRAMES_PER_ROUND),
        .EXT_LO           (EXT_LO),
        .EXT_HI           (EXT_HI)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .acc_en_i  (accept),
        .first_i   (first),
        .is_min_i  (is_min),
        .data_i    (bus.frm_data),
        .ext_nxt_o (ext_nxt),
        .avg_nxt_o (avg_nxt),
        .in_rng_o  (in_rng),
        .out_rng_o (out_rng)
    );

`ifdef IOT_SCHED_PEAK_EN
    logic [DATA_W-1:0] peak_q, peak_d;
    logic              seen_q, seen_d;
    logic              peak_clr;

    // Clearing at frame 0 guarantees the first round under a new peak mode emits.
    assign peak_clr = accept && first && ((bus.fn_sel != fn_q) || !is_peak(bus.fn_sel));

    always_comb begin
        peak_ok = !seen_q || ((fn_eff == FN_PMAX) ? (ext_nxt > peak_q) : (ext_nxt < peak_q));
        peak_d  = peak_q;
        seen_d  = seen_q;
        if (peak_clr) begin
            peak_d = '0;
            seen_d = 1'b0;
        end else if (emit && is_peak(fn_eff)) begin
            peak_d = ext_nxt;
            seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
            seen_q <= 1'b0;
        end else begin
            peak_q <= peak_d;
            seen_q <= seen_d;
        end
    end
`else
    assign peak_ok = 1'b1;
`endif

    always_comb begin
        sel_emit = 1'b0;
        sel_data = ext_nxt;
        case (fn_eff)
            FN_MAX, FN_MIN: sel_emit = last;
            FN_AVG: begin
                sel_emit = last;
                sel_data = avg_nxt;
            end
            FN_EXT: begin
                sel_emit = in_rng;
                sel_data = bus.frm_data;
            end
            FN_EXC: begin
                sel_emit = out_rng;
                sel_data = bus.frm_data;
            end
            FN_PMAX, FN_PMIN: sel_emit = last && peak_ok;
            default: sel_emit = 1'b0;
        endcase
        emit = accept && sel_emit;

        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = S_COLLECT;
            S_COLLECT: state_d = emit ? S_EMIT : S_COLLECT;
            S_EMIT:    state_d = S_COLLECT;
            default:   state_d = S_IDLE;
        endcase

        idx_d = idx_q;
        fn_d  = fn_q;
        if (accept) begin
            idx_d = last ? '0 : (idx_q + IDX_W'(1));
            if (first) fn_d = bus.fn_sel;
        end

        out_d = emit ? sel_data : out_q;
        vld_d = emit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            fn_q    <= FN_RSVD;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fn_q    <= fn_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

endmodule

// File: tb/tb_iot_fn_sched.sv
// Directed scoreboard bench for iot_fn_sched: stimulus pushes expected results, a monitor pops them.
module tb_iot_fn_sched;
    import iot_pkg::*;

    localparam logic [127:0] LO = 128'h6FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [127:0] HI = 128'hAFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_at_edge = 1'b0;
    logic done = 1'b0;

    logic [127:0] exp_q[$];
    int pass_cnt = 0;
    int total_cnt = 0;
    logic [127:0] vals [8];

    iot_fn_sched_if bus ();

    iot_fn_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rst_at_edge <= rst;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    // Offer one frame and return once it has been accepted.
    task automatic send(input logic [2:0] f, input logic [127:0] d);
        int k;
        @(negedge clk);
        bus.fn_sel   = f;
        bus.frm_data = d;
        bus.frm_vld  = 1'b1;
        k = 0;
        while (!bus.frm_rdy) begin
            k++;
            if (k > 20) begin
                $display("FAIL accept_timeout: got frm_rdy=0 for %0d cycles required 1", k);
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.frm_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: reset-state checks while in reset, scoreboard pop on every valid.
    initial begin
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (rst_at_edge) begin
                chk("rst_valid", {127'b0, bus.valid}, 128'd0);
                chk("rst_iot_out", bus.iot_out, 128'd0);
                chk("rst_frm_rdy", {127'b0, bus.frm_rdy}, 128'd0);
            end else if (bus.valid) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_valid: got iot_out=%0h required no valid", bus.iot_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("iot_out", bus.iot_out, e);
                    chk("frm_rdy_in_emit", {127'b0, bus.frm_rdy}, 128'd0);
                end
            end
        end
        chk("results_outstanding", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        bus.fn_sel   = FN_RSVD;
        bus.frm_vld  = 1'b0;
        bus.frm_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // max over 1..8
        exp_q.push_back(128'd8);
        for (int i = 1; i <= 8; i++) send(FN_MAX, 128'(i));
        idle(2);

        // avg of 8x10, then of 1..8
        exp_q.push_back(128'd10);
        for (int i = 0; i < 8; i++) send(FN_AVG, 128'd10);
        exp_q.push_back(128'd4);
        for (int i = 1; i <= 8; i++) send(FN_AVG, 128'(i));
        idle(2);

        // extract: only LO+1 is strictly inside; fillers are 0
        exp_q.push_back(LO + 128'd1);
        send(FN_EXT, LO); send(FN_EXT, LO + 128'd1); send(FN_EXT, HI); send(FN_EXT, 128'd0);
        for (int i = 0; i < 4; i++) send(FN_EXT, 128'd0);
        // exclude: only 0 is outside; boundary fillers never emit
        exp_q.push_back(128'd0);
        send(FN_EXC, LO); send(FN_EXC, LO + 128'd1); send(FN_EXC, HI); send(FN_EXC, 128'd0);
        for (int i = 0; i < 4; i++) send(FN_EXC, HI);
        idle(2);

        // peak-max rounds with extremes 50, 40, 60
        exp_q.push_back(128'd50);
`ifndef IOT_SCHED_PEAK_EN
        exp_q.push_back(128'd40);
`endif
        exp_q.push_back(128'd60);
        send(FN_PMAX, 128'd50);
        for (int i = 0; i < 7; i++) send(FN_PMAX, 128'd5);
        for (int i = 0; i < 7; i++) send(FN_PMAX, 128'd6);
        send(FN_PMAX, 128'd40);
        for (int i = 0; i < 3; i++) send(FN_PMAX, 128'd7);
        send(FN_PMAX, 128'd60);
        for (int i = 0; i < 4; i++) send(FN_PMAX, 128'd8);
        idle(2);

        // reserved code: a full round produces nothing
        for (int i = 0; i < 8; i++) send(FN_RSVD, 128'(100 + i));
        idle(2);

        // partial min round discarded by reset, then a clean round of 7s
        for (int i = 0; i < 5; i++) send(FN_MIN, 128'd3);
        @(negedge clk);
        bus.frm_vld = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(128'd7);
        for (int i = 0; i < 8; i++) send(FN_MIN, 128'd7);
        idle(2);

        // fn changes 001->010 mid-round: that round is max, the next is min
        vals[0] = 128'd5; vals[1] = 128'd9; vals[2] = 128'd2; vals[3] = 128'd7;
        vals[4] = 128'd3; vals[5] = 128'd8; vals[6] = 128'd4; vals[7] = 128'd6;
        exp_q.push_back(128'd9);
        for (int i = 0; i < 8; i++) send((i < 3) ? FN_MAX : FN_MIN, vals[i]);
        exp_q.push_back(128'd2);
        for (int i = 0; i < 8; i++) send(FN_MIN, vals[i]);
        idle(4);

        done = 1'b1;
    end

endmodule
